// File: rtl/mbm_pkg.sv
// Shared constants and types for the multi-bank memory scheduler.
// Widths follow the default geometry below; the top-level parameters default to these values.
// Override geometry here, not on the instance, so the derived widths stay consistent.
package mbm_pkg;

  localparam int MBM_N_REQ  = 4;
  localparam int MBM_N_BANK = 4;
  localparam int MBM_ADDR_W = 8;
  localparam int MBM_DATA_W = 32;

  // Bank-select bits come from the bottom of the word address.
  localparam int BSEL_W  = $clog2(MBM_N_BANK);
  localparam int BADDR_W = MBM_ADDR_W - BSEL_W;
  localparam int REQID_W = $clog2(MBM_N_REQ);

  // One outstanding read per bank: who asked for it.
  typedef struct packed {
    logic                vld;
    logic [REQID_W-1:0]  id;
  } rd_tag_t;

endpackage

// File: rtl/mbm_rr_bank_arb.sv
// Per-bank round-robin arbiter: first candidate at or after the pointer, searching upward cyclically.
// Latency: purely combinational, grant in the same cycle as the candidates.
// Backpressure: none; losing candidates simply see no grant and retry.
module mbm_rr_bank_arb #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    i_cand,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_id
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_keep;
  logic [2*N-1:0] w_msk;
  logic [2*N-1:0] w_iso;

  // Duplicate the candidates so the wrap-around search becomes a plain lowest-set-bit search
  // over the doubled vector, starting at bit ptr.
  assign w_dbl  = {i_cand, i_cand};
  assign w_keep = {(2*N){1'b1}} << i_ptr;
  assign w_msk  = w_dbl & w_keep;
  assign w_iso  = w_msk & (-w_msk);
  // Fold the two halves back; only one bit can survive the isolation.
  assign o_gnt  = w_iso[N-1:0] | w_iso[2*N-1:N];

  // One-hot to binary encode of the winner.
  always_comb begin
    o_id = '0;
    for (int k = 0; k < N; k++) begin
      if (o_gnt[k]) begin
        o_id = o_id | ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/mbm_bank_scheduler.sv
// Shares N_BANK single-port SRAM banks among N_REQ requesters; bank = low address bits, RR per bank.
// Latency: grant/bank strobe same cycle as request; read data returned to the requester one cycle later.
// Backpressure: req_ready withheld from arbitration losers; responses are never stalled.
module mbm_bank_scheduler
  import mbm_pkg::*;
#(
  parameter int N_REQ  = MBM_N_REQ,
  parameter int N_BANK = MBM_N_BANK,
  parameter int ADDR_W = MBM_ADDR_W,
  parameter int DATA_W = MBM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [N_REQ*DATA_W-1:0]   resp_rdata,
  output logic [N_BANK-1:0]         bank_en,
  output logic [N_BANK-1:0]         bank_we,
  output logic [N_BANK*BADDR_W-1:0] bank_addr,
  output logic [N_BANK*DATA_W-1:0]  bank_wdata,
  input  logic [N_BANK*DATA_W-1:0]  bank_rdata
);

  logic [N_REQ-1:0]   w_cand [N_BANK];
  logic [N_REQ-1:0]   w_gnt  [N_BANK];
  logic [REQID_W-1:0] w_win  [N_BANK];
  logic [N_BANK-1:0]  w_any;
  logic [REQID_W-1:0] r_ptr  [N_BANK];
  rd_tag_t            r_tag  [N_BANK];

  // Address decode: each valid requester is a candidate on exactly one bank; nothing competes in reset.
  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      w_cand[b] = '0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      for (int b = 0; b < N_BANK; b++) begin
        if (!rst && req_valid[i] && (req_addr[i*ADDR_W +: BSEL_W] == BSEL_W'(b))) begin
          w_cand[b][i] = 1'b1;
        end
      end
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_arb
    mbm_rr_bank_arb #(
      .N    (N_REQ),
      .ID_W (REQID_W)
    ) u_arb (
      .i_cand (w_cand[b]),
      .i_ptr  (r_ptr[b]),
      .o_gnt  (w_gnt[b]),
      .o_id   (w_win[b])
    );
    assign w_any[b] = |w_gnt[b];
  end

  // Bank-side muxes from each bank's winner; idle banks drive zeros. Grants OR into req_ready.
  always_comb begin
    int k;
    k          = 0;
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    req_ready  = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (w_any[b]) begin
        k                                = int'(w_win[b]);
        bank_en[b]                       = 1'b1;
        bank_we[b]                       = req_we[k];
        bank_addr[b*BADDR_W +: BADDR_W]  = req_addr[k*ADDR_W + BSEL_W +: BADDR_W];
        bank_wdata[b*DATA_W +: DATA_W]   = req_wdata[k*DATA_W +: DATA_W];
        req_ready                        = req_ready | w_gnt[b];
      end
    end
  end

  // Advance each bank pointer past its winner and remember who issued a read for the return path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < N_BANK; b++) begin
        r_ptr[b] <= '0;
        r_tag[b] <= '0;
      end
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        if (w_any[b]) begin
          r_ptr[b]     <= (w_win[b] == REQID_W'(N_REQ-1)) ? '0 : w_win[b] + REQID_W'(1);
          r_tag[b].vld <= !req_we[int'(w_win[b])];
          r_tag[b].id  <= w_win[b];
        end else begin
          r_tag[b].vld <= 1'b0;
        end
      end
    end
  end

  // Response demux: a requester is granted on at most one bank, so tags never collide on an id.
  always_comb begin
    int k;
    k          = 0;
    resp_valid = '0;
    resp_rdata = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (r_tag[b].vld) begin
        k                               = int'(r_tag[b].id);
        resp_valid[k]                   = 1'b1;
        resp_rdata[k*DATA_W +: DATA_W]  = bank_rdata[b*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_mbm_bank_scheduler.sv
// Self-checking bench for mbm_bank_scheduler: directed scenarios plus a randomized run.
// Reference: per-bank round-robin pointers and a flat word memory kept in plain arrays.
// Banks are modelled as single-port SRAMs with one-cycle read latency.
module tb_mbm_bank_scheduler;

  localparam int N_REQ   = 4;
  localparam int N_BANK  = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int BADDR_W = 6;

  logic                      clk;
  logic                      rst;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_we;
  logic [N_REQ*ADDR_W-1:0]   req_addr;
  logic [N_REQ*DATA_W-1:0]   req_wdata;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ-1:0]          resp_valid;
  logic [N_REQ*DATA_W-1:0]   resp_rdata;
  logic [N_BANK-1:0]         bank_en;
  logic [N_BANK-1:0]         bank_we;
  logic [N_BANK*BADDR_W-1:0] bank_addr;
  logic [N_BANK*DATA_W-1:0]  bank_wdata;
  logic [N_BANK*DATA_W-1:0]  bank_rdata;

  int n_cmp;
  int n_bad;

  // Reference state
  logic [DATA_W-1:0] ref_mem [256];
  int                m_ptr   [N_BANK];
  int                m_win   [N_BANK];
  logic [N_REQ-1:0]  m_rdy;
  logic [N_BANK-1:0] m_en;
  logic [N_REQ-1:0]  pend_vld;
  logic [DATA_W-1:0] pend_dat [N_REQ];
  int                wcnt     [N_REQ];

  // Bank SRAM model
  logic [DATA_W-1:0] bmem [N_BANK][64];
  logic              bwr  [N_BANK][64];

  mbm_bank_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .bank_en    (bank_en),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A3C_0F96;
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < N_BANK; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) begin
          bmem[b][bank_addr[b*BADDR_W +: BADDR_W]] <= bank_wdata[b*DATA_W +: DATA_W];
          bwr[b][bank_addr[b*BADDR_W +: BADDR_W]]  <= 1'b1;
        end else if (bwr[b][bank_addr[b*BADDR_W +: BADDR_W]] === 1'b1) begin
          bank_rdata[b*DATA_W +: DATA_W] <= bmem[b][bank_addr[b*BADDR_W +: BADDR_W]];
        end else begin
          bank_rdata[b*DATA_W +: DATA_W] <= init_val(int'(bank_addr[b*BADDR_W +: BADDR_W]) * N_BANK + b);
        end
      end
    end
  end

  function automatic logic [ADDR_W-1:0] get_addr(input int i);
    return req_addr[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] get_wdata(input int i);
    return req_wdata[i*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] get_rdata(input int i);
    return resp_rdata[i*DATA_W +: DATA_W];
  endfunction

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid[i]                  = v;
    req_we[i]                     = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Expected grants from the current inputs: per bank, the first valid requester targeting it,
  // scanning upward from the pointer with wrap-around.
  task automatic model_calc();
    int k;
    m_rdy = '0;
    m_en  = '0;
    for (int b = 0; b < N_BANK; b++) begin
      m_win[b] = -1;
      for (int off = 0; off < N_REQ; off++) begin
        k = (m_ptr[b] + off) % N_REQ;
        if (m_win[b] < 0 && req_valid[k] && (int'(get_addr(k)) % N_BANK) == b) m_win[b] = k;
      end
      if (m_win[b] >= 0) begin
        m_en[b]          = 1'b1;
        m_rdy[m_win[b]]  = 1'b1;
      end
    end
  endtask

  // Commit the model for this cycle and step to just after the next rising edge.
  task automatic adv();
    int k;
    int a;
    model_calc();
    pend_vld = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (m_en[b]) begin
        k = m_win[b];
        a = int'(get_addr(k));
        if (req_we[k]) begin
          ref_mem[a] = get_wdata(k);
        end else begin
          pend_vld[k] = 1'b1;
          pend_dat[k] = ref_mem[a];
        end
        m_ptr[b] = (k + 1) % N_REQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b0, 8'(i*4), 32'h0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want %b", req_ready, 4'b0000); end
    n_cmp++; if (bank_en !== 4'b0000) begin n_bad++; $display("FAIL reset_bank_en: got %b want %b", bank_en, 4'b0000); end
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_resp_valid: got %b want %b", resp_valid, 4'b0000); end
    n_cmp++; if (resp_rdata !== '0) begin n_bad++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant: got %b want %b", req_ready, 4'b0001); end
    adv();
    n_cmp++; if (resp_valid !== 4'b0001 || get_rdata(0) !== ref_mem[0]) begin
      n_bad++; $display("FAIL reset_pre_read: got %b/%h want 0001/%h", resp_valid, get_rdata(0), ref_mem[0]);
    end
    #1;
    rst = 1'b1;
    for (int b = 0; b < N_BANK; b++) m_ptr[b] = 0;
    pend_vld = '0;
    #1;
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL midrst_resp_valid: got %b want %b", resp_valid, 4'b0000); end
    n_cmp++; if (resp_rdata !== '0) begin n_bad++; $display("FAIL midrst_resp_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (bank_en !== 4'b0000 || req_ready !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_en_ready: got %b/%b want 0000/0000", bank_en, req_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL midrst_ptr_cleared: got %b want %b", req_ready, 4'b0001); end
    req_valid = '0;
    adv();
  endtask

  task automatic test_no_conflict();
    req_valid = '0;
    set_req(0, 1'b1, 1'b0, 8'h00, 32'h0);
    set_req(1, 1'b1, 1'b0, 8'h01, 32'h0);
    #1;
    n_cmp++; if (req_ready !== 4'b0011) begin n_bad++; $display("FAIL noconf_ready: got %b want %b", req_ready, 4'b0011); end
    n_cmp++; if (bank_en !== 4'b0011 || bank_we !== 4'b0000) begin
      n_bad++; $display("FAIL noconf_bank_en: got %b/%b want 0011/0000", bank_en, bank_we);
    end
    adv();
    req_valid = '0;
    n_cmp++; if (resp_valid !== 4'b0011) begin n_bad++; $display("FAIL noconf_resp_valid: got %b want %b", resp_valid, 4'b0011); end
    n_cmp++; if (get_rdata(0) !== ref_mem[0] || get_rdata(1) !== ref_mem[1] || get_rdata(2) !== 32'h0) begin
      n_bad++; $display("FAIL noconf_rdata: got %h %h %h want %h %h 0", get_rdata(0), get_rdata(1), get_rdata(2), ref_mem[0], ref_mem[1]);
    end
    adv();
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL noconf_resp_idle: got %b want %b", resp_valid, 4'b0000); end
  endtask

  task automatic test_conflict();
    logic [N_REQ-1:0] exp_r;
    logic [N_REQ-1:0] prev_r;
    req_valid = '0;
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b0, 8'(i*16 + 2), 32'h0);
    prev_r = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_r = '0;
      exp_r[c % N_REQ] = 1'b1;
      n_cmp++; if (req_ready !== exp_r) begin n_bad++; $display("FAIL conflict_grant%0d: got %b want %b", c, req_ready, exp_r); end
      n_cmp++; if (bank_en !== 4'b0100) begin n_bad++; $display("FAIL conflict_bank_en%0d: got %b want %b", c, bank_en, 4'b0100); end
      n_cmp++; if (resp_valid !== prev_r) begin n_bad++; $display("FAIL conflict_resp%0d: got %b want %b", c, resp_valid, prev_r); end
      prev_r = exp_r;
      adv();
    end
    req_valid = '0;
    #1;
    n_cmp++; if (resp_valid !== 4'b0001 || get_rdata(0) !== ref_mem[2]) begin
      n_bad++; $display("FAIL conflict_last_data: got %b/%h want 0001/%h", resp_valid, get_rdata(0), ref_mem[2]);
    end
    adv();
  endtask

  task automatic test_ptr_wrap();
    // Bank 1 pointer is 2 here; one grant to R2 moves it to 3.
    req_valid = '0;
    set_req(2, 1'b1, 1'b0, 8'h05, 32'h0);
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL wrap_setup: got %b want %b", req_ready, 4'b0100); end
    adv();
    req_valid = '0;
    set_req(1, 1'b1, 1'b0, 8'h09, 32'h0);
    set_req(3, 1'b1, 1'b0, 8'h0D, 32'h0);
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL wrap_r3_first: got %b want %b", req_ready, 4'b1000); end
    adv();
    req_valid[3] = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_r1_second: got %b want %b", req_ready, 4'b0010); end
    n_cmp++; if (resp_valid !== 4'b1000 || get_rdata(3) !== ref_mem[8'h0D]) begin
      n_bad++; $display("FAIL wrap_r3_data: got %b/%h want 1000/%h", resp_valid, get_rdata(3), ref_mem[8'h0D]);
    end
    adv();
    set_req(0, 1'b1, 1'b0, 8'h01, 32'h0);
    set_req(1, 1'b1, 1'b0, 8'h09, 32'h0);
    set_req(2, 1'b1, 1'b0, 8'h05, 32'h0);
    set_req(3, 1'b1, 1'b0, 8'h0D, 32'h0);
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL wrap_ptr_is_2: got %b want %b", req_ready, 4'b0100); end
    adv();
    req_valid = '0;
    adv();
  endtask

  task automatic test_write_read();
    req_valid = '0;
    set_req(2, 1'b1, 1'b1, 8'h15, 32'hDEADBEEF);
    #1;
    n_cmp++; if (req_ready !== 4'b0100 || bank_en !== 4'b0010 || bank_we !== 4'b0010) begin
      n_bad++; $display("FAIL wr_strobes: got rdy %b en %b we %b want 0100/0010/0010", req_ready, bank_en, bank_we);
    end
    n_cmp++; if (bank_addr[BADDR_W +: BADDR_W] !== 6'd5 || bank_wdata[DATA_W +: DATA_W] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL wr_bank_bus: got %h/%h want 05/deadbeef", bank_addr[BADDR_W +: BADDR_W], bank_wdata[DATA_W +: DATA_W]);
    end
    n_cmp++; if (bank_addr[0 +: BADDR_W] !== 6'd0 || bank_wdata[0 +: DATA_W] !== 32'h0) begin
      n_bad++; $display("FAIL wr_idle_bank_zero: got %h/%h want 0/0", bank_addr[0 +: BADDR_W], bank_wdata[0 +: DATA_W]);
    end
    adv();
    set_req(2, 1'b1, 1'b0, 8'h15, 32'h0);
    #1;
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL wr_no_resp: got %b want %b", resp_valid, 4'b0000); end
    n_cmp++; if (req_ready !== 4'b0100 || bank_we !== 4'b0000) begin
      n_bad++; $display("FAIL rd_grant: got %b/%b want 0100/0000", req_ready, bank_we);
    end
    adv();
    req_valid = '0;
    #1;
    n_cmp++; if (resp_valid !== 4'b0100 || get_rdata(2) !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL rd_after_wr: got %b/%h want 0100/deadbeef", resp_valid, get_rdata(2));
    end
    adv();
  endtask

  task automatic test_random();
    logic [N_REQ*DATA_W-1:0] exp_rd;
    int b;
    req_valid = '0;
    for (int i = 0; i < N_REQ; i++) wcnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i]) begin
          wcnt[i] = 0;
          if ($urandom_range(3) != 0)
            set_req(i, 1'b1, 1'($urandom_range(1)), 8'($urandom), 32'($urandom));
        end else if ($urandom_range(31) == 0) begin
          req_valid[i] = 1'b0;
          wcnt[i] = 0;
        end
      end
      #1;
      model_calc();
      exp_rd = '0;
      for (int i = 0; i < N_REQ; i++) if (pend_vld[i]) exp_rd[i*DATA_W +: DATA_W] = pend_dat[i];
      n_cmp++; if (req_ready !== m_rdy) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, req_ready, m_rdy); end
      n_cmp++; if (bank_en !== m_en) begin n_bad++; $display("FAIL rnd_bank_en c%0d: got %b want %b", cyc, bank_en, m_en); end
      n_cmp++; if (resp_valid !== pend_vld) begin n_bad++; $display("FAIL rnd_resp_valid c%0d: got %b want %b", cyc, resp_valid, pend_vld); end
      n_cmp++; if (resp_rdata !== exp_rd) begin n_bad++; $display("FAIL rnd_resp_rdata c%0d: got %h want %h", cyc, resp_rdata, exp_rd); end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i]) begin
          b = int'(get_addr(i)) % N_BANK;
          if (req_ready[i]) begin
            n_cmp++; if (wcnt[i] > N_REQ-1) begin n_bad++; $display("FAIL rnd_starve r%0d: waited %0d grants, limit %0d", i, wcnt[i], N_REQ-1); end
            wcnt[i] = 0;
          end else if (bank_en[b]) begin
            wcnt[i]++;
          end
        end
      end
      adv();
      for (int i = 0; i < N_REQ; i++) if (m_rdy[i]) req_valid[i] = 1'b0;
    end
    req_valid = '0;
    adv();
    adv();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
    for (int b = 0; b < N_BANK; b++) m_ptr[b] = 0;
    pend_vld  = '0;
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_no_conflict();
    test_conflict();
    test_ptr_wrap();
    test_write_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
